dr_alm_pipe: RTL and testbench

DR_ALM_PIPE -- requirements
Module: dr_alm_pipe

---
 rtl/dr_alm_pipe.sv | 152 +++++++++++++++
 tb/tb_dr_alm_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_alm_pipe.sv
// Three-stage approximate log multiplier with valid/ready handshake.
// Stages: sign/abs/leading-one, truncate/add, antilog/shift/sign.
module dr_alm_pipe #(
   parameter int WIDTH    = 16,
   parameter int KEEP_MAX = 6,
   parameter int TAG_W    = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [WIDTH-1:0]                i_a,
   input  logic [WIDTH-1:0]                i_b,
   input  logic                            i_signed,
   input  logic [$clog2(KEEP_MAX+1)-1:0]   i_keep,
   input  logic [TAG_W-1:0]                i_tag,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [2*WIDTH-1:0]              o_z,
   output logic [TAG_W-1:0]                o_tag,
   output logic                            o_busy
);

   localparam int KW = $clog2(KEEP_MAX+1);
   localparam int KB = $clog2(WIDTH);
   localparam int EB = KB + 1;
   localparam int FW = WIDTH - 1;
   localparam int XW = KEEP_MAX - 1;
   localparam int TW = KEEP_MAX + 1;
   localparam int ZW = 2 * WIDTH;
   localparam int PW = ZW + TW;

   function automatic logic [KB-1:0] lod(input logic [WIDTH-1:0] x);
      logic [KB-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++)
         if (x[i]) r = KB'(i);
      return r;
   endfunction

   function automatic logic [FW-1:0] align(input logic [WIDTH-1:0] x,
                                           input logic [KB-1:0] k);
      return FW'(x << (KB'(WIDTH-1) - k));
   endfunction

   logic en;
   assign en = !o_valid | i_ready;
   assign o_ready = en;

   // stage 1
   logic             sa, sb;
   logic [WIDTH-1:0] ma, mb;
   logic [KB-1:0]    la, lb;
   logic [KW-1:0]    teff;

   always_comb begin
      sa = i_signed & i_a[WIDTH-1];
      sb = i_signed & i_b[WIDTH-1];
      ma = sa ? -i_a : i_a;
      mb = sb ? -i_b : i_b;
      la = lod(ma);
      lb = lod(mb);
      if (i_keep < KW'(2))
         teff = KW'(2);
      else if (i_keep > KW'(KEEP_MAX))
         teff = KW'(KEEP_MAX);
      else
         teff = i_keep;
   end

   logic             v1, n1, z1;
   logic [FW-1:0]    fa, fb;
   logic [KB-1:0]    ka, kb;
   logic [KW-1:0]    t1;
   logic [TAG_W-1:0] g1;

   // stage 2
   logic [EB-1:0] sh;
   logic [XW:0]   xa, xb;
   logic [TW-1:0] s, lim, m;
   logic [EB-1:0] e;

   always_comb begin
      sh  = EB'(WIDTH) - EB'(t1);
      xa  = {XW'(fa >> sh), 1'b1};
      xb  = {XW'(fb >> sh), 1'b1};
      s   = TW'(xa) + TW'(xb);
      lim = TW'(1) << t1;
      if (s < lim) begin
         m = s + lim;
         e = EB'(ka) + EB'(kb);
      end else begin
         m = s;
         e = EB'(ka) + EB'(kb) + EB'(1);
      end
   end

   logic             v2, n2, z2;
   logic [TW-1:0]    m2;
   logic [EB-1:0]    e2;
   logic [KW-1:0]    t2;
   logic [TAG_W-1:0] g2;

   // stage 3
   logic [ZW-1:0] mag, res;

   always_comb begin
      mag = ZW'((PW'(m2) << e2) >> t2);
      if (z2)
         res = '0;
      else if (n2)
         res = -mag;
      else
         res = mag;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1 <= 1'b0; n1 <= 1'b0; z1 <= 1'b0;
         fa <= '0; fb <= '0; ka <= '0; kb <= '0;
         t1 <= '0; g1 <= '0;
         v2 <= 1'b0; n2 <= 1'b0; z2 <= 1'b0;
         m2 <= '0; e2 <= '0; t2 <= '0; g2 <= '0;
         o_valid <= 1'b0;
         o_z     <= '0;
         o_tag   <= '0;
      end else if (en) begin
         v1 <= i_valid;
         n1 <= sa ^ sb;
         z1 <= (ma == '0) | (mb == '0);
         fa <= align(ma, la);
         fb <= align(mb, lb);
         ka <= la;
         kb <= lb;
         t1 <= teff;
         g1 <= i_tag;
         v2 <= v1;
         n2 <= n1;
         z2 <= z1;
         m2 <= m;
         e2 <= e;
         t2 <= t1;
         g2 <= g1;
         o_valid <= v2;
         o_z     <= res;
         o_tag   <= g2;
      end
   end

   assign o_busy = v1 | v2 | o_valid;

endmodule

// File: tb/tb_dr_alm_pipe.sv
// Randomized bench for dr_alm_pipe against a queue-based arithmetic model.
// Directed literal cases pin the model; one negedge process checks every cycle.
module tb_dr_alm_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, o_ready, i_signed, o_valid, i_ready, o_busy;
   logic [15:0] i_a, i_b;
   logic [2:0]  i_keep;
   logic [3:0]  i_tag, o_tag;
   logic [31:0] o_z;

   int errors = 0;
   int checks = 0;
   int outs   = 0;

   typedef struct {
      logic [31:0] z;
      logic [3:0]  tag;
      int          age;
   } ent_t;

   ent_t q[$];

   dr_alm_pipe dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_keep(i_keep),
      .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_z(o_z),
      .o_tag(o_tag), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input bit sg, input int keep);
      longint aa, bb, xa, xb, s, mm, mag;
      int teff, ka, kb, e;
      bit neg;
      teff = keep < 2 ? 2 : (keep > 6 ? 6 : keep);
      aa = (sg && a[15]) ? 65536 - longint'(a) : longint'(a);
      bb = (sg && b[15]) ? 65536 - longint'(b) : longint'(b);
      if (aa == 0 || bb == 0) return 32'd0;
      ka = 0;
      while ((64'd1 << (ka + 1)) <= aa) ka++;
      kb = 0;
      while ((64'd1 << (kb + 1)) <= bb) kb++;
      xa = ((aa - (64'd1 << ka)) * (64'd1 << (teff - 1))) / (64'd1 << ka);
      xb = ((bb - (64'd1 << kb)) * (64'd1 << (teff - 1))) / (64'd1 << kb);
      s = 2 * xa + 1 + 2 * xb + 1;
      if (s < (64'd1 << teff)) begin
         mm = s + (64'd1 << teff);
         e  = ka + kb;
      end else begin
         mm = s;
         e  = ka + kb + 1;
      end
      mag = (mm << e) >> teff;
      neg = sg && (a[15] ^ b[15]);
      return neg ? 32'(-mag) : 32'(mag);
   endfunction

   // cycle-level reference: entries age by one on every advancing edge
   always @(negedge clk) begin
      bit ev;
      if (rst) begin
         q.delete();
      end else begin
         ev = q.size() > 0 && q[0].age == 3;
         chk("o_valid", 64'(o_valid), 64'(ev));
         if (ev) begin
            chk("o_z", 64'(o_z), 64'(q[0].z));
            chk("o_tag", 64'(o_tag), 64'(q[0].tag));
         end
         chk("o_busy", 64'(o_busy), 64'(q.size() != 0));
         chk("o_ready", 64'(o_ready), 64'(!ev || i_ready));
         if (!ev || i_ready) begin
            if (ev) begin
               void'(q.pop_front());
               outs++;
            end
            foreach (q[i]) q[i].age++;
            if (i_valid)
               q.push_back('{model(i_a, i_b, i_signed, int'(i_keep)),
                             i_tag, 1});
         end
      end
   end

   task automatic dir(input logic [15:0] a, input logic [15:0] b,
                      input bit sg, input logic [2:0] k,
                      input logic [3:0] t, input logic [31:0] z);
      @(posedge clk); #1;
      i_ready = 1'b1; i_valid = 1'b1;
      i_a = a; i_b = b; i_signed = sg; i_keep = k; i_tag = t;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("dir_valid", 64'(o_valid), 64'd1);
      chk("dir_z", 64'(o_z), 64'(z));
      chk("dir_tag", 64'(o_tag), 64'(t));
   endtask

   task automatic drain();
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (q.size() == 0) break;
         @(posedge clk); #1;
      end
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int sent, o0, acc;
      rst = 1'b1;
      i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0;
      i_signed = 1'b0; i_keep = 3'd6; i_tag = '0;
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_z", 64'(o_z), 64'd0);
      chk("rst_tag", 64'(o_tag), 64'd0);

      chk("m_3x5", 64'(model(16'd3, 16'd5, 1, 6)), 64'd14);
      chk("m_3x3", 64'(model(16'd3, 16'd3, 1, 6)), 64'd8);
      chk("m_n3x5", 64'(model(16'hFFFD, 16'd5, 1, 6)), 64'hFFFFFFF2);
      chk("m_min", 64'(model(16'h8000, 16'h8000, 1, 6)), 64'd1107296256);
      chk("m_max", 64'(model(16'hFFFF, 16'hFFFF, 0, 6)), 64'd4227858432);
      chk("m_k0", 64'(model(16'd3, 16'd5, 1, 0)), 64'd16);
      chk("m_k7", 64'(model(16'd3, 16'd5, 1, 7)), 64'd14);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      dir(16'd3, 16'd5, 1, 3'd6, 4'd1, 32'd14);
      dir(16'd3, 16'd3, 1, 3'd6, 4'd2, 32'd8);
      dir(16'hFFFD, 16'd5, 1, 3'd6, 4'd3, 32'hFFFFFFF2);
      dir(16'h8000, 16'h8000, 1, 3'd6, 4'd4, 32'd1107296256);
      dir(16'hFFFF, 16'hFFFF, 0, 3'd6, 4'd5, 32'd4227858432);
      dir(16'd0, 16'hFFFF, 1, 3'd3, 4'd6, 32'd0);
      dir(16'h8000, 16'd0, 0, 3'd0, 4'd7, 32'd0);
      dir(16'd3, 16'd5, 1, 3'd0, 4'd8, 32'd16);
      dir(16'd3, 16'd5, 1, 3'd7, 4'd9, 32'd14);
      drain();

      // back-to-back stream under a 1,0,0,1 ready pattern
      sent = 0;
      o0 = outs;
      for (int c = 0; c < 200 && (sent < 8 || q.size() > 0); c++) begin
         @(posedge clk); #1;
         i_ready = (c % 4 == 0) || (c % 4 == 3);
         i_valid = sent < 8;
         i_a = 16'($urandom); i_b = 16'($urandom);
         i_signed = 1'b1; i_keep = 3'd6; i_tag = 4'(sent);
         @(negedge clk);
         if (i_valid && o_ready) sent++;
      end
      chk("stream_out", 64'(outs - o0), 64'd8);
      drain();

      // full throughput with ready held high
      acc = 0;
      o0 = outs;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         i_ready = 1'b1; i_valid = 1'b1;
         i_a = 16'($urandom); i_b = 16'($urandom);
         i_signed = 1'($urandom); i_keep = 3'($urandom); i_tag = 4'(c);
         @(negedge clk);
         if (o_ready) acc++;
      end
      chk("thru_acc", 64'(acc), 64'd20);
      drain();
      chk("thru_out", 64'(outs - o0), 64'd20);

      // random traffic with corner operands
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 5))
            0: i_a = 16'd0;
            1: i_a = 16'h8000;
            2: i_a = 16'hFFFF;
            default: i_a = 16'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: i_b = 16'd0;
            1: i_b = 16'h8000;
            2: i_b = 16'd1;
            default: i_b = 16'($urandom);
         endcase
         i_signed = 1'($urandom);
         i_keep = 3'($urandom);
         i_tag = 4'($urandom);
      end
      drain();

      // reset with three beats in flight
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         i_valid = 1'b1; i_ready = 1'b1;
         i_a = 16'd100 + 16'(c); i_b = 16'd7; i_signed = 1'b0;
         i_keep = 3'd5; i_tag = 4'(10 + c);
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("pre_rst_valid", 64'(o_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_busy", 64'(o_busy), 64'd0);
      chk("mid_rst_ready", 64'(o_ready), 64'd1);
      chk("mid_rst_z", 64'(o_z), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      i_valid = 1'b1; i_a = 16'd3; i_b = 16'd3;
      i_signed = 1'b1; i_keep = 3'd6; i_tag = 4'd12;
      @(posedge clk); #1;
      i_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(o_valid), 64'd1);
      chk("post_rst_z", 64'(o_z), 64'd8);
      chk("post_rst_tag", 64'(o_tag), 64'd12);
      drain();
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
